// File: rtl/xge_pkg.sv
// Shared types and constants for the 10G packet receive sink.
// Flag bit positions match the {TIMEOUT, OVERSIZE, FRAMING, MAC_ERR} status layout.
package xge_pkg;

  typedef enum logic [1:0] {IDLE, READ, DONE} rx_sink_state_t;

  typedef struct packed {
    logic timeout;
    logic oversize;
    logic framing;
    logic mac_err;
  } rx_stat_flags_t;

  localparam int WORD_BYTES    = 8;
  localparam int LEN_W         = 14;
  localparam int FLAG_MAC_ERR  = 0;
  localparam int FLAG_FRAMING  = 1;
  localparam int FLAG_OVERSIZE = 2;
  localparam int FLAG_TIMEOUT  = 3;

  // Keep bytes below mod in an EOP word; mod of zero means the whole word is valid.
  function automatic logic [63:0] byte_mask(input logic [2:0] mod);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (mod == 3'd0 || b < int'(mod)) m[b*8 +: 8] = 8'hff;
    end
    return m;
  endfunction

endpackage

// File: rtl/xge_sat_cnt.sv
// Saturating accumulator: adds 'add' when inc is high, sticks at all-ones.
// Single-cycle update; clr wins over inc; no backpressure.
module xge_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] add,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt} + {1'b0, add};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/xge_pkt_rx_sink.sv
// Drains MAC pkt_rx packets, checks framing, emits one status record per packet plus stats.
// EOP (or timeout) to stat_valid is 1 cycle; ren drops combinationally on the EOP word.
module xge_pkt_rx_sink
  import xge_pkg::*;
#(
  parameter int MAX_BYTES = 9600,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             enable,
  input  logic             clr_cnt,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             stat_valid,
  output logic [13:0]      stat_len,
  output logic [3:0]       stat_flags,
  output logic [31:0]      stat_sig,
  output logic [CNT_W-1:0] cnt_pkts,
  output logic [CNT_W-1:0] cnt_bytes,
  output logic [CNT_W-1:0] cnt_errs
);

  localparam int          TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MAX_U = 32'(MAX_BYTES);

  rx_sink_state_t state, state_nxt;

  logic [LEN_W-1:0] len_q, len_nxt, fin_len;
  logic [LEN_W:0]   len_sum;
  logic [31:0]      sig_q, sig_nxt, fin_sig;
  logic [63:0]      masked;
  logic [3:0]       word_bytes;
  rx_stat_flags_t   flags_q, flags_nxt, fin_flags;
  logic             seen_q;
  logic [TMR_W-1:0] tmr_q;
  logic             word_ok, eop_word, tmo_hit;

  assign word_ok  = (state == READ) && pkt_rx_val;
  assign eop_word = word_ok && pkt_rx_eop;
  assign tmo_hit  = (state == READ) && !pkt_rx_val && (tmr_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && pkt_rx_avail) state_nxt = READ;
      READ:    if (eop_word || tmo_hit)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_rx_ren = (state == READ) && !(pkt_rx_val && pkt_rx_eop);
    stat_valid = (state == DONE);
  end

  always_comb begin
    word_bytes = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'(WORD_BYTES);
    len_sum    = {1'b0, len_q} + (LEN_W+1)'(word_bytes);
    len_nxt    = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    masked     = pkt_rx_data & (pkt_rx_eop ? byte_mask(pkt_rx_mod) : {64{1'b1}});
    sig_nxt    = sig_q ^ masked[63:32] ^ masked[31:0];

    // A single-word packet carries sop on the first word, so it is legal.
    flags_nxt          = flags_q;
    flags_nxt.framing  = flags_q.framing | (seen_q ? pkt_rx_sop : !pkt_rx_sop);
    flags_nxt.oversize = flags_q.oversize | (32'(len_nxt) > MAX_U);
    flags_nxt.mac_err  = flags_q.mac_err | (pkt_rx_eop & pkt_rx_err);

    fin_len           = word_ok ? len_nxt   : len_q;
    fin_sig           = word_ok ? sig_nxt   : sig_q;
    fin_flags         = word_ok ? flags_nxt : flags_q;
    fin_flags.timeout = tmo_hit;
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      len_q      <= '0;
      sig_q      <= '0;
      flags_q    <= '0;
      seen_q     <= 1'b0;
      tmr_q      <= '0;
      stat_len   <= '0;
      stat_sig   <= '0;
      stat_flags <= '0;
    end else if (state == IDLE) begin
      len_q   <= '0;
      sig_q   <= '0;
      flags_q <= '0;
      seen_q  <= 1'b0;
      tmr_q   <= '0;
    end else if (state == READ) begin
      if (pkt_rx_val) begin
        len_q   <= len_nxt;
        sig_q   <= sig_nxt;
        flags_q <= flags_nxt;
        seen_q  <= 1'b1;
        tmr_q   <= '0;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end
      if (eop_word || tmo_hit) begin
        stat_len                  <= fin_len;
        stat_sig                  <= fin_sig;
        stat_flags[FLAG_TIMEOUT]  <= fin_flags.timeout;
        stat_flags[FLAG_OVERSIZE] <= fin_flags.oversize;
        stat_flags[FLAG_FRAMING]  <= fin_flags.framing;
        stat_flags[FLAG_MAC_ERR]  <= fin_flags.mac_err;
      end
    end
  end

  xge_sat_cnt #(.CNT_W(CNT_W)) u_cnt_pkts (
    .clk(clk_156m25), .rst_n(reset_156m25_n), .clr(clr_cnt),
    .inc(stat_valid), .add(CNT_W'(1)), .cnt(cnt_pkts)
  );

  xge_sat_cnt #(.CNT_W(CNT_W)) u_cnt_bytes (
    .clk(clk_156m25), .rst_n(reset_156m25_n), .clr(clr_cnt),
    .inc(stat_valid), .add(CNT_W'(stat_len)), .cnt(cnt_bytes)
  );

  xge_sat_cnt #(.CNT_W(CNT_W)) u_cnt_errs (
    .clk(clk_156m25), .rst_n(reset_156m25_n), .clr(clr_cnt),
    .inc(stat_valid && (stat_flags != 4'd0)), .add(CNT_W'(1)), .cnt(cnt_errs)
  );

endmodule

// File: tb/tb_xge_pkt_rx_sink.sv
// Randomized MAC-side stimulus against a byte-level reference model of the receive sink.
module tb_xge_pkt_rx_sink;

  localparam int     MAXB = 64;
  localparam int     TMO  = 64;
  localparam int     CW   = 16;
  localparam longint CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, clr_cnt = 1'b0, pkt_rx_avail = 1'b0;
  logic          pkt_rx_ren;
  logic [63:0]   pkt_rx_data = '0;
  logic          pkt_rx_val = 1'b0, pkt_rx_sop = 1'b0, pkt_rx_eop = 1'b0, pkt_rx_err = 1'b0;
  logic [2:0]    pkt_rx_mod = '0;
  logic          stat_valid;
  logic [13:0]   stat_len;
  logic [3:0]    stat_flags;
  logic [31:0]   stat_sig;
  logic [CW-1:0] cnt_pkts, cnt_bytes, cnt_errs;

  xge_pkt_rx_sink #(.MAX_BYTES(MAXB), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_data(pkt_rx_data),
    .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
    .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err), .stat_valid(stat_valid),
    .stat_len(stat_len), .stat_flags(stat_flags), .stat_sig(stat_sig),
    .cnt_pkts(cnt_pkts), .cnt_bytes(cnt_bytes), .cnt_errs(cnt_errs)
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;
  longint m_pkts = 0, m_bytes = 0, m_errs = 0;

  logic [63:0] q_dat[$];
  logic        q_sop[$], q_eop[$], q_err[$];
  logic [2:0]  q_mod[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_pkt(input int nbytes, input bit no_sop, input bit extra_sop, input bit err);
    int nw;
    nw = (nbytes + 7) / 8;
    q_dat.delete(); q_sop.delete(); q_eop.delete(); q_err.delete(); q_mod.delete();
    for (int i = 0; i < nw; i++) begin
      q_dat.push_back({$urandom, $urandom});
      q_sop.push_back(i == 0 ? !no_sop : (extra_sop && i == nw / 2));
      q_eop.push_back(i == nw - 1);
      q_mod.push_back(i == nw - 1 ? 3'(nbytes % 8) : 3'($urandom));
      q_err.push_back(i == nw - 1 ? err : 1'($urandom));
    end
  endtask

  task automatic idle_inputs();
    pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
    pkt_rx_err = 1'b0; pkt_rx_mod = '0;  pkt_rx_data = '0;
  endtask

  // Expected record for the first ndel words of the current packet.
  task automatic model(input int ndel, input bit tmo, output int e_len,
                       output logic [31:0] e_sig, output logic [3:0] e_flags);
    bit fr, ov, me;
    int nb;
    logic [63:0] d, w;
    e_len = 0; e_sig = '0; fr = 0; ov = 0; me = 0;
    for (int i = 0; i < ndel; i++) begin
      nb = (q_eop[i] && q_mod[i] != 3'd0) ? int'(q_mod[i]) : 8;
      d = q_dat[i];
      w = '0;
      for (int b = 0; b < 8; b++) if (b < nb) w[b*8 +: 8] = d[b*8 +: 8];
      e_sig = e_sig ^ w[31:0] ^ w[63:32];
      e_len = e_len + nb;
      if (e_len > 16383) e_len = 16383;
      if (e_len > MAXB) ov = 1;
      if (i == 0 && !q_sop[i]) fr = 1;
      if (i > 0 && q_sop[i]) fr = 1;
      if (q_eop[i] && q_err[i]) me = 1;
    end
    e_flags = {tmo, ov, fr, me};
  endtask

  task automatic xfer(input int ndel, input int gap_pct, input bit tmo, input int drop_en_at,
                      input bit keep_avail, input bit clr_in_done, output logic [31:0] got_sig);
    int idx = 0, cyc = 0, eop_cyc = -1, last_val_cyc = -1, budget, e_len;
    bit ren_prev = 0, seen = 0, ren_ok = 1;
    logic [31:0] e_sig;
    logic [3:0]  e_flags;
    logic [13:0] o_len = '0;
    logic [3:0]  o_flags = '0;
    got_sig = '0;
    model(ndel, tmo, e_len, e_sig, e_flags);
    budget = ndel * 4 + 200;
    pkt_rx_avail = 1'b1;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stat_valid) begin
        seen = 1;
        o_len = stat_len; o_flags = stat_flags; got_sig = stat_sig;
        idle_inputs();
        pkt_rx_avail = keep_avail;
      end else begin
        if (ren_prev && idx < ndel && $urandom_range(99) >= gap_pct) begin
          pkt_rx_val = 1'b1;     pkt_rx_data = q_dat[idx]; pkt_rx_sop = q_sop[idx];
          pkt_rx_eop = q_eop[idx]; pkt_rx_mod = q_mod[idx]; pkt_rx_err = q_err[idx];
          if (q_eop[idx]) eop_cyc = cyc;
          last_val_cyc = cyc;
          idx++;
          if (idx == drop_en_at) enable = 1'b0;
        end else begin
          pkt_rx_val = 1'b0; pkt_rx_data = {$urandom, $urandom}; pkt_rx_sop = 1'($urandom);
          pkt_rx_eop = 1'($urandom); pkt_rx_mod = 3'($urandom); pkt_rx_err = 1'($urandom);
        end
        #1;
        if (idx > 0 && eop_cyc < 0 && !pkt_rx_ren) ren_ok = 0;
        if (eop_cyc == cyc && pkt_rx_ren) ren_ok = 0;
        ren_prev = pkt_rx_ren;
      end
    end
    if (!seen) begin
      idle_inputs();
      pkt_rx_avail = keep_avail;
    end
    check("stat_valid_seen", 64'(seen), 64'd1);
    if (tmo) check("timeout_latency", 64'(cyc - last_val_cyc), 64'(TMO + 1));
    else     check("eop_latency", 64'(cyc - eop_cyc), 64'd1);
    check("stat_len", 64'(o_len), 64'(e_len));
    check("stat_sig", 64'(got_sig), 64'(e_sig));
    check("stat_flags", 64'(o_flags), 64'(e_flags));
    check("ren_shape", 64'(ren_ok), 64'd1);
    if (clr_in_done) begin
      m_pkts = 0; m_bytes = 0; m_errs = 0;
    end else begin
      m_pkts  = (m_pkts + 1 > CMAX) ? CMAX : m_pkts + 1;
      m_bytes = (m_bytes + e_len > CMAX) ? CMAX : m_bytes + e_len;
      if (e_flags != 4'd0) m_errs = (m_errs + 1 > CMAX) ? CMAX : m_errs + 1;
    end
    clr_cnt = clr_in_done;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("stat_valid_pulse", 64'(stat_valid), 64'd0);
    check("cnt_pkts", 64'(cnt_pkts), 64'(m_pkts));
    check("cnt_bytes", 64'(cnt_bytes), 64'(m_bytes));
    check("cnt_errs", 64'(cnt_errs), 64'(m_errs));
  endtask

  initial begin
    logic [31:0] sig_a, sig_b;
    logic [63:0] d;
    bit ren_seen, stat_seen;
    int nb;

    repeat (3) @(negedge clk);
    check("rst_ren", 64'(pkt_rx_ren), 64'd0);
    check("rst_stat_valid", 64'(stat_valid), 64'd0);
    check("rst_stat_len", 64'(stat_len), 64'd0);
    check("rst_stat_flags", 64'(stat_flags), 64'd0);
    check("rst_stat_sig", 64'(stat_sig), 64'd0);
    check("rst_cnt_pkts", 64'(cnt_pkts), 64'd0);
    check("rst_cnt_bytes", 64'(cnt_bytes), 64'd0);
    check("rst_cnt_errs", 64'(cnt_errs), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // enable low: nothing is read even with avail high
    pkt_rx_avail = 1'b1;
    ren_seen = 0;
    repeat (10) begin @(negedge clk); #1; if (pkt_rx_ren) ren_seen = 1; end
    check("no_read_when_disabled", 64'(ren_seen), 64'd0);
    pkt_rx_avail = 1'b0;
    enable = 1'b1;

    build_pkt(64, 0, 0, 0);  xfer(8, 0, 0, -1, 0, 0, sig_a);
    build_pkt(61, 0, 0, 0);  xfer(8, 0, 0, -1, 0, 0, sig_a);
    d = q_dat[7]; d[63:40] = ~d[63:40]; q_dat[7] = d;
    xfer(8, 20, 0, -1, 0, 0, sig_b);
    check("sig_ignores_masked_bytes", 64'(sig_b), 64'(sig_a));

    build_pkt(40, 1, 0, 0);  xfer(5, 0, 0, -1, 0, 0, sig_a);
    build_pkt(40, 0, 1, 0);  xfer(5, 10, 0, -1, 0, 0, sig_a);
    build_pkt(72, 0, 0, 0);  xfer(9, 0, 0, -1, 0, 0, sig_a);
    build_pkt(5, 0, 0, 0);   xfer(1, 0, 0, -1, 0, 0, sig_a);
    build_pkt(30, 0, 0, 1);  xfer(4, 0, 0, -1, 0, 0, sig_a);
    build_pkt(80, 0, 0, 0);  xfer(3, 0, 1, -1, 0, 0, sig_a);

    // back-to-back with enable dropped during the second packet
    build_pkt(48, 0, 0, 0);  xfer(6, 0, 0, -1, 1, 0, sig_a);
    build_pkt(56, 0, 0, 0);  xfer(7, 15, 0, 2, 1, 0, sig_a);
    ren_seen = 0; stat_seen = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (pkt_rx_ren) ren_seen = 1;
      if (stat_valid) stat_seen = 1;
    end
    check("third_pkt_not_read", 64'(ren_seen), 64'd0);
    check("no_extra_record", 64'(stat_seen), 64'd0);
    enable = 1'b1;
    build_pkt(24, 0, 0, 0);  xfer(3, 0, 0, -1, 0, 1, sig_a);

    for (int p = 0; p < 25; p++) begin
      nb = int'($urandom_range(150, 1));
      build_pkt(nb, ($urandom_range(9) == 0), ($urandom_range(9) == 0), 1'($urandom));
      xfer((nb + 7) / 8, int'($urandom_range(30)), 0, -1, 0, 0, sig_a);
    end

    // stat_len and cnt_bytes saturation
    for (int p = 0; p < 5; p++) begin
      build_pkt(16800, 0, 0, 0);
      xfer(2100, 0, 0, -1, 0, 0, sig_a);
    end

    // reset in the middle of a packet
    build_pkt(80, 0, 0, 0);
    pkt_rx_avail = 1'b1;
    for (int c = 0; c < 20 && !pkt_rx_ren; c++) @(negedge clk);
    check("ren_before_reset", 64'(pkt_rx_ren), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pkt_rx_val = 1'b1; pkt_rx_data = q_dat[i]; pkt_rx_sop = q_sop[i];
      pkt_rx_eop = 1'b0; pkt_rx_mod = '0; pkt_rx_err = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    pkt_rx_avail = 1'b0;
    #1;
    check("midrst_ren", 64'(pkt_rx_ren), 64'd0);
    check("midrst_stat_valid", 64'(stat_valid), 64'd0);
    check("midrst_cnt_pkts", 64'(cnt_pkts), 64'd0);
    check("midrst_cnt_bytes", 64'(cnt_bytes), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pkts = 0; m_bytes = 0; m_errs = 0;
    build_pkt(64, 0, 0, 0);  xfer(8, 0, 0, -1, 0, 0, sig_a);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
